// File: rtl/uart_rx_buffer.sv
// uart_rx_buffer: 8N1 UART receiver feeding a byte FIFO with a valid/ready pop side.
//   clk_i, rst_ni        : clock, async active-low reset
//   rx_i                 : serial line (async, idles high)
//   data_o/valid_o       : FIFO head byte / FIFO non-empty
//   ready_i              : consumer pops the head byte when valid_o is high
//   clear_i              : flush FIFO and clear overflow_o
//   fill_o               : FIFO occupancy 0..FifoDepth
//   frame_err_o          : one-cycle pulse when a stop bit samples low
//   overflow_o           : sticky, a byte was dropped because the FIFO was full
module uart_rx_buffer #(
  parameter int Freq       = 500_000,
  parameter int Baud       = 115_200,
  parameter int ClksPerBit = Freq / Baud,
  parameter int FifoDepth  = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         rx_i,
  output logic [7:0]                   data_o,
  output logic                         valid_o,
  input  logic                         ready_i,
  input  logic                         clear_i,
  output logic [$clog2(FifoDepth):0]   fill_o,
  output logic                         frame_err_o,
  output logic                         overflow_o
);

  localparam int HalfBit = ClksPerBit / 2;
  localparam int CntW    = $clog2(ClksPerBit * 10);
  localparam int PtrW    = $clog2(FifoDepth);

  // Cycle counter is cleared in cycle S, so it reads n-1 in cycle S+n.
  localparam logic [CntW-1:0] StartTgt = CntW'(HalfBit - 1);
  localparam logic [CntW-1:0] StopTgt  = CntW'(HalfBit + 9 * ClksPerBit - 1);
  localparam logic [PtrW:0]   FullCnt  = (PtrW + 1)'(FifoDepth);

  if (ClksPerBit < 4) begin : g_bad_cpb
    $error("uart_rx_buffer: ClksPerBit must be >= 4");
  end
  if (FifoDepth < 2 || (FifoDepth & (FifoDepth - 1)) != 0) begin : g_bad_depth
    $error("uart_rx_buffer: FifoDepth must be a power of two >= 2");
  end

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_e;

  state_e            r_state, w_state_nxt;
  logic [1:0]        r_sync;
  logic              w_rx_s;
  logic [CntW-1:0]   r_cnt;
  logic [2:0]        r_bit_idx;
  logic [7:0]        r_shift;
  logic              r_frame_err;
  logic [CntW-1:0]   w_data_tgt;
  logic              w_cnt_clr, w_shift_en, w_push, w_ferr;

  assign w_rx_s     = r_sync[1];
  assign w_data_tgt = CntW'(HalfBit - 1 + ClksPerBit * (int'(r_bit_idx) + 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sync      <= 2'b11;
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_sync      <= {r_sync[0], rx_i};
      r_state     <= w_state_nxt;
      r_frame_err <= w_ferr;
      if (w_cnt_clr) begin
        r_cnt     <= '0;
        r_bit_idx <= '0;
      end else begin
        if (r_state != IDLE && r_state != WAIT_HIGH) r_cnt <= r_cnt + 1'b1;
        if (w_shift_en) r_bit_idx <= r_bit_idx + 1'b1;
      end
      if (w_shift_en) r_shift <= {w_rx_s, r_shift[7:1]};
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_clr   = 1'b0;
    w_shift_en  = 1'b0;
    w_push      = 1'b0;
    w_ferr      = 1'b0;
    case (r_state)
      IDLE: if (!w_rx_s) begin
        w_state_nxt = START;
        w_cnt_clr   = 1'b1;
      end
      START: if (r_cnt == StartTgt) w_state_nxt = w_rx_s ? IDLE : DATA;
      DATA: if (r_cnt == w_data_tgt) begin
        w_shift_en = 1'b1;
        if (r_bit_idx == 3'd7) w_state_nxt = STOP;
      end
      STOP: if (r_cnt == StopTgt) begin
        if (w_rx_s) begin
          w_push      = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_ferr      = 1'b1;
          w_state_nxt = WAIT_HIGH;
        end
      end
      WAIT_HIGH: if (w_rx_s) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // FIFO
  logic [7:0]      r_mem [FifoDepth];
  logic [PtrW-1:0] r_wr_ptr, r_rd_ptr;
  logic [PtrW:0]   r_fill;
  logic            r_ovf;
  logic            w_pop, w_full, w_wr_ok;

  assign w_pop   = valid_o && ready_i;
  assign w_full  = (r_fill == FullCnt);
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign w_wr_ok = w_push && (!w_full || w_pop) && !clear_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_fill   <= '0;
      r_ovf    <= 1'b0;
    end else if (clear_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_fill   <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push && w_full && !w_pop) r_ovf <= 1'b1;
      if (w_wr_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)   r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr_ok, w_pop})
        2'b10:   r_fill <= r_fill + 1'b1;
        2'b01:   r_fill <= r_fill - 1'b1;
        default: r_fill <= r_fill;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < FifoDepth; i++) r_mem[i] <= '0;
    end else if (w_wr_ok) begin
      r_mem[r_wr_ptr] <= r_shift;
    end
  end

  assign data_o      = r_mem[r_rd_ptr];
  assign valid_o     = (r_fill != '0);
  assign fill_o      = r_fill;
  assign frame_err_o = r_frame_err;
  assign overflow_o  = r_ovf;

endmodule
